// File: rtl/dac_sc1.sv
// Streaming Intel-HEX loader: parses one ASCII character per enabled clock and
// issues a byte write (AB/DB with active-low WE) for each data byte of a type-00 record.
module dac_sc1 (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        EN,
  input  logic [7:0]  DI,
  output logic [15:0] AB,
  output logic [7:0]  DB,
  output logic        WE,
  output logic        ERR
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NW = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_TYPE = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] hi_q, hi_d;
  logic          dig_q, dig_d;
  logic [DW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] len_q, len_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] type_q, type_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [AW-1:0] ab_q, ab_d;
  logic [DW-1:0] db_q, db_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic          is_hex_c;
  logic [NW-1:0] nib_c;
  logic [DW-1:0] byte_c;
  logic [DW-1:0] sum_c;

  // ASCII hex digit decode (upper and lower case)
  always_comb begin
    is_hex_c = 1'b1;
    nib_c    = '0;
    if (DI >= 8'h30 && DI <= 8'h39)      nib_c = NW'(DI - 8'h30);
    else if (DI >= 8'h41 && DI <= 8'h46) nib_c = NW'(DI - 8'h37);
    else if (DI >= 8'h61 && DI <= 8'h66) nib_c = NW'(DI - 8'h57);
    else                                 is_hex_c = 1'b0;
  end

  assign byte_c = {hi_q, nib_c};
  assign sum_c  = DW'(sum_q + byte_c);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    dig_d   = dig_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    base_d  = base_q;
    type_d  = type_q;
    sum_d   = sum_q;
    ab_d    = ab_q;
    db_d    = db_q;
    we_d    = 1'b1;
    err_d   = err_q;
    if (EN) begin
      if (state_q == S_IDLE) begin
        if (DI == 8'h3A) begin
          state_d = S_LEN;
          sum_d   = '0;
          dig_d   = 1'b0;
          bcnt_d  = '0;
        end
      end else if (state_q != S_DONE) begin
        if (!is_hex_c) begin
          // a stray character (':' included) abandons the record
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!dig_q) begin
          hi_d  = nib_c;
          dig_d = 1'b1;
        end else begin
          dig_d = 1'b0;
          sum_d = sum_c;
          case (state_q)
            S_LEN: begin
              len_d   = byte_c;
              bcnt_d  = '0;
              state_d = S_ADDR;
            end
            S_ADDR: begin
              if (!bcnt_q[0]) begin
                base_d[15:8] = byte_c;
                bcnt_d       = DW'(1);
              end else begin
                base_d[7:0] = byte_c;
                state_d     = S_TYPE;
              end
            end
            S_TYPE: begin
              type_d  = byte_c;
              bcnt_d  = '0;
              state_d = (len_q == '0) ? S_CHK : S_DATA;
            end
            S_DATA: begin
              // writes go out as bytes arrive, before the checksum is known
              if (type_q == '0) begin
                ab_d = AW'(base_q + AW'(bcnt_q));
                db_d = byte_c;
                we_d = 1'b0;
              end
              bcnt_d = DW'(bcnt_q + DW'(1));
              if (bcnt_d == len_q) state_d = S_CHK;
            end
            S_CHK: begin
              if (sum_c != '0) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end else if (type_q == DW'(1)) begin
                state_d = S_DONE;
              end else begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      dig_q   <= 1'b0;
      bcnt_q  <= '0;
      len_q   <= '0;
      base_q  <= '0;
      type_q  <= '0;
      sum_q   <= '0;
      ab_q    <= '0;
      db_q    <= '0;
      we_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      dig_q   <= dig_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      type_q  <= type_d;
      sum_q   <= sum_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign AB  = ab_q;
  assign DB  = db_q;
  assign WE  = we_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_dac_sc1.sv
// Bench for dac_sc1: directed Intel-HEX records plus randomized records; expected
// writes are queued from a record-level model and popped by a WE monitor.
`timescale 1ns/1ps
module tb_dac_sc1;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        EN  = 1'b0;
  logic [7:0]  DI  = 8'h00;
  logic [15:0] AB;
  logic [7:0]  DB;
  logic        WE;
  logic        ERR;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  exp_err  = 1'b0;
  bit  exp_done = 1'b0;
  bit  gaps_en  = 1'b0;

  dac_sc1 dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .DI(DI),
    .AB(AB), .DB(DB), .WE(WE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every WE-low cycle must match the oldest expected write
  always @(negedge CLK) begin
    if (CLR && WE === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'h0, AB, DB}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(AB), 32'(w.a));
        check("write_data", 32'(DB), 32'(w.d));
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    if (!exp_done) exp_q.push_back(w);
  endtask

  task automatic send_char(input byte c);
    if (gaps_en && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        @(negedge CLK);
        EN = 1'b0;
        DI = 8'($urandom);
      end
    end
    @(negedge CLK);
    EN = 1'b1;
    DI = c;
    @(posedge CLK);
    #1;
    EN = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain_check(input string name);
    repeat (2) @(negedge CLK);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_err"}, 32'(ERR), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0;
    EN  = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    CLR = 1'b1;
  endtask

  function automatic string hx(input logic [7:0] b, input bit lc);
    return lc ? $sformatf("%02x", b) : $sformatf("%02X", b);
  endfunction

  // One random record built from its fields; expected writes follow the field layout
  task automatic random_record();
    int unsigned n;
    logic [15:0] base;
    logic [7:0]  typ, sum, chk;
    logic [7:0]  dat[8];
    bit          lc, bad_chk, inject;
    int unsigned p;
    string       s, bads, sep;
    n    = $urandom_range(0, 5);
    base = 16'($urandom);
    typ  = ($urandom_range(0, 9) < 7) ? 8'h00 : 8'($urandom_range(2, 5));
    lc   = 1'($urandom);
    sum  = 8'(n) + base[15:8] + base[7:0] + typ;
    s    = {":", hx(8'(n), lc), hx(base[15:8], lc), hx(base[7:0], lc), hx(typ, lc)};
    for (int k = 0; k < int'(n); k++) begin
      dat[k] = 8'($urandom);
      sum    = sum + dat[k];
      s      = {s, hx(dat[k], lc)};
    end
    chk     = 8'(0) - sum;
    bad_chk = ($urandom_range(0, 6) == 0);
    if (bad_chk) chk = chk ^ 8'(1 << $urandom_range(0, 7));
    s      = {s, hx(chk, lc)};
    inject = ($urandom_range(0, 7) == 0);
    p      = 0;
    if (inject) begin
      int unsigned j;
      bads = "G:z \r";
      j    = $urandom_range(0, 4);
      p    = $urandom_range(1, s.len() - 1);
      s    = {s.substr(0, int'(p) - 1), bads.substr(int'(j), int'(j))};
    end
    // byte k completes at character index 10+2k
    if (typ == 8'h00) begin
      for (int k = 0; k < int'(n); k++)
        if (!inject || (10 + 2 * k) < int'(p)) push_wr(16'(base + 16'(k)), dat[k]);
    end
    if (inject || bad_chk) exp_err = 1'b1;
    sep = " \r\n";
    repeat ($urandom_range(0, 2)) begin
      int unsigned q;
      q = $urandom_range(0, 2);
      send_str(sep.substr(int'(q), int'(q)));
    end
    send_str(s);
    drain_check("rand_record");
  endtask

  initial begin
    #17;
    check("rst_ab",  32'(AB),  32'h0000);
    check("rst_db",  32'(DB),  32'h00);
    check("rst_we",  32'(WE),  32'h1);
    check("rst_err", 32'(ERR), 32'h0);
    @(negedge CLK);
    CLR = 1'b1;

    push_wr(16'h00FF, 8'h3C);
    push_wr(16'h0100, 8'h00);
    send_str(":0200FF003C00C3");
    drain_check("two_bytes");

    push_wr(16'hFFFF, 8'hAB);
    send_str(":01FFFF00AB56");
    drain_check("top_addr");
    push_wr(16'hFFFF, 8'h11);
    push_wr(16'h0000, 8'h22);
    send_str(":02ffff001122cd");
    drain_check("addr_wrap");

    send_str(" :00000001FF");
    exp_done = 1'b1;
    send_str(":0100000055AA");
    drain_check("done_ignores");

    do_reset();
    push_wr(16'h0010, 8'h42);
    send_str(":0100100042A");
    check("err_before_chk", 32'(ERR), 32'h0);
    send_str("E");
    exp_err = 1'b1;
    check("err_bad_chk", 32'(ERR), 32'h1);
    push_wr(16'h0020, 8'h11);
    send_str(":0100200011CE");
    drain_check("err_sticky");

    do_reset();
    send_str(":01");
    check("pre_g_err", 32'(ERR), 32'h0);
    send_str("G");
    exp_err = 1'b1;
    check("g_edge_err", 32'(ERR), 32'h1);
    send_str("0");
    send_str(":00000001FF");
    exp_done = 1'b1;
    send_str(":0100000055AA");
    drain_check("nonhex_then_done");

    do_reset();
    send_str(":0412300011");
    check("mid_we",  32'(WE), 32'h0);
    check("mid_ab",  32'(AB), 32'h1230);
    check("mid_db",  32'(DB), 32'h11);
    #1;
    CLR = 1'b0;
    #1;
    check("arst_ab",  32'(AB),  32'h0000);
    check("arst_db",  32'(DB),  32'h00);
    check("arst_we",  32'(WE),  32'h1);
    check("arst_err", 32'(ERR), 32'h0);
    @(negedge CLK);
    CLR = 1'b1;
    push_wr(16'h1234, 8'hAA);
    send_str(":01123400AA0F");
    drain_check("after_reset");

    gaps_en = 1'b1;
    for (int r = 0; r < 60; r++) random_record();
    send_str(":00000001FF");
    exp_done = 1'b1;
    random_record();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
